// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer: streams a program into imem, holds the core in reset, then runs it to a halt PC under a cycle watchdog
//  clk, reset (async, active-high)
//  start                                   : restart pulse, honoured only when not busy
//  load_valid/load_ready/load_data/load_last : program word stream
//  imem_we/imem_waddr/imem_wdata           : registered imem write port
//  halt_pc/core_pc                         : halt detection while running
//  core_resetn                             : registered active-low core reset
//  busy/done/timeout/overflow/cycle_count  : status
module imem_boot_sequencer #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int MAX_CYCLES = 1024,
  parameter int CW         = 16,
  parameter int RESET_HOLD = 2,
  localparam int AW = IMEM_DEPTH > 1 ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_last,
  input  logic [XLEN-1:0] halt_pc,
  input  logic [XLEN-1:0] core_pc,
  output logic            imem_we,
  output logic [AW-1:0]   imem_waddr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_resetn,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic            overflow,
  output logic [CW-1:0]   cycle_count
);
  localparam int HW = RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE, TIMEOUT, OVF} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] wcnt_q, imem_waddr_q;
  logic [HW-1:0] hcnt_q;
  logic [XLEN-1:0] imem_wdata_q;
  logic [CW-1:0] cycle_count_q;
  logic imem_we_q, core_resetn_q, done_q, timeout_q, overflow_q;
  logic accept, restart;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, TIMEOUT, OVF: state_d = start ? LOAD : state_q;
      LOAD: state_d = !accept ? LOAD : load_last ? HOLD : wcnt_q == AW'(IMEM_DEPTH - 1) ? OVF : LOAD;
      HOLD: state_d = hcnt_q == HW'(RESET_HOLD - 1) ? RUN : HOLD;
      RUN:  state_d = core_pc == halt_pc ? DONE : cycle_count_q == CW'(MAX_CYCLES - 1) ? TIMEOUT : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    load_ready = state_q == LOAD;
    busy = state_q inside {LOAD, HOLD, RUN};
    accept = load_valid & load_ready;
    restart = start & ~busy;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wcnt_q        <= '0;
      hcnt_q        <= '0;
      imem_we_q     <= 1'b0;
      imem_waddr_q  <= '0;
      imem_wdata_q  <= '0;
      core_resetn_q <= 1'b0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      imem_we_q <= accept;
      if (accept) begin
        imem_waddr_q <= wcnt_q;
        imem_wdata_q <= load_data;
      end
      wcnt_q        <= restart ? '0 : accept ? wcnt_q + 1'b1 : wcnt_q;
      hcnt_q        <= state_q == HOLD ? hcnt_q + 1'b1 : '0;
      // driven from next state so the core sees a clean registered edge on RUN entry/exit
      core_resetn_q <= state_d == RUN;
      // counts only while staying in RUN so the exit cycle's count is what remains visible
      cycle_count_q <= restart ? '0 :
                       (state_q == RUN && state_d == RUN && !(&cycle_count_q)) ? cycle_count_q + 1'b1 :
                       cycle_count_q;
      done_q        <= !restart && (done_q || (state_q == RUN && state_d == DONE));
      timeout_q     <= !restart && (timeout_q || (state_q == RUN && state_d == TIMEOUT));
      overflow_q    <= !restart && (overflow_q || (state_q == LOAD && state_d == OVF));
    end
  assign imem_we     = imem_we_q;
  assign imem_waddr  = imem_waddr_q;
  assign imem_wdata  = imem_wdata_q;
  assign core_resetn = core_resetn_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_imem_boot_sequencer.sv
// tb_imem_boot_sequencer: randomized load/run/check bench against a behavioural expectation model
module tb_imem_boot_sequencer;
  localparam int XLEN = 32, DEPTH = 8, MAXC = 16, CW = 16, HOLD = 2, AW = 3;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [XLEN-1:0] load_data = '0, halt_pc = '0, core_pc = '0;
  logic load_ready, imem_we, core_resetn, busy, done, timeout, overflow;
  logic [AW-1:0] imem_waddr;
  logic [XLEN-1:0] imem_wdata;
  logic [CW-1:0] cycle_count;
  logic [XLEN-1:0] prog [0:15];
  int checks = 0, failures = 0;
  bit ok;
  imem_boot_sequencer #(.XLEN(XLEN), .IMEM_DEPTH(DEPTH), .MAX_CYCLES(MAXC), .CW(CW), .RESET_HOLD(HOLD)) u_dut (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .halt_pc(halt_pc), .core_pc(core_pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_resetn(core_resetn),
    .busy(busy), .done(done), .timeout(timeout), .overflow(overflow), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals;
    chk("rst_we", imem_we, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_rstn", core_resetn, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", cycle_count, 0);
  endtask
  task automatic async_reset;
    #3 reset = 1'b1;
    #1 chk_reset_vals();
    load_valid = 1'b0;
    start = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);
  endtask
  task automatic do_start;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", load_ready, 1);
    chk("start_done", done, 0);
    chk("start_timeout", timeout, 0);
    chk("start_ovf", overflow, 0);
    chk("start_cnt", cycle_count, 0);
    chk("start_rstn", core_resetn, 0);
  endtask
  // expected: word i lands at address i; the DEPTH-th word without last ends in overflow
  task automatic do_load(input int n, input bit toggle, output bit ok_o);
    int i = 0, cyc = 0;
    bit v = 1'b0;
    ok_o = 1'b0;
    while (i < n && cyc < 400) begin
      v = toggle ? ~v : 1'($urandom_range(0, 1));
      load_valid = v;
      load_data = prog[i];
      load_last = (i == n - 1);
      start = 1'($urandom_range(0, 4) == 0);
      chk("ld_ready", load_ready, 1);
      step();
      cyc++;
      chk("ld_we", imem_we, v);
      if (v) begin
        chk("ld_addr", imem_waddr, i);
        chk("ld_data", imem_wdata, prog[i]);
        if (i == n - 1) begin
          load_valid = 1'b0;
          load_last = 1'b0;
          start = 1'b0;
          chk("hold_busy", busy, 1);
          chk("hold_ready", load_ready, 0);
          chk("hold_rstn", core_resetn, 0);
          for (int h = 0; h < HOLD - 1; h++) begin
            step();
            chk("hold_rstn_low", core_resetn, 0);
            chk("hold_we", imem_we, 0);
          end
          step();
          chk("run_rstn_rise", core_resetn, 1);
          chk("run_cnt0", cycle_count, 0);
          ok_o = 1'b1;
        end else if (i == DEPTH - 1) begin
          chk("ovf_flag", overflow, 1);
          chk("ovf_busy", busy, 0);
          chk("ovf_ready", load_ready, 0);
          load_valid = 1'b1;
          load_data = prog[i + 1];
          load_last = 1'b0;
          start = 1'b0;
          step();
          chk("ovf_no_we", imem_we, 0);
          chk("ovf_addr_hold", imem_waddr, DEPTH - 1);
          chk("ovf_sticky", overflow, 1);
          load_valid = 1'b0;
          i = n;
        end
        i++;
      end
    end
    start = 1'b0;
    load_valid = 1'b0;
    if (cyc >= 400) chk("ld_cycle_budget", 0, 1);
  endtask
  // halt_at < 0 means the halt PC is never presented
  task automatic do_run(input int halt_at);
    int fin = (halt_at >= 0) ? halt_at : MAXC - 1;
    for (int r = 0; r < MAXC; r++) begin
      core_pc = (r == halt_at) ? halt_pc : halt_pc + 32'(4 * r + 4);
      start = 1'($urandom_range(0, 5) == 0);
      chk("run_cnt", cycle_count, r);
      chk("run_rstn", core_resetn, 1);
      chk("run_busy", busy, 1);
      step();
      if (r == fin) break;
    end
    start = 1'b0;
    chk("end_done", done, halt_at >= 0);
    chk("end_timeout", timeout, halt_at < 0);
    chk("end_cnt", cycle_count, fin);
    chk("end_rstn", core_resetn, 0);
    chk("end_busy", busy, 0);
    core_pc = halt_pc;
    repeat (3) step();
    chk("hold_cnt", cycle_count, fin);
    chk("hold_done", done, halt_at >= 0);
    chk("hold_timeout", timeout, halt_at < 0);
    chk("hold_rstn_frozen", core_resetn, 0);
  endtask
  task automatic rand_prog;
    for (int k = 0; k < 16; k++) prog[k] = $urandom;
    halt_pc = $urandom & 32'hffff_fffc;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "bench timeout");
  end
  initial begin
    rand_prog();
    step();
    step();
    chk_reset_vals();
    reset = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    prog[0] = 32'h01908093; prog[1] = 32'h04b10113; prog[2] = 32'h002080b3;
    prog[3] = 32'h40208133; prog[4] = 32'h402080b3;
    halt_pc = 32'h14;
    do_start();
    do_load(5, 1'b0, ok);
    chk("dir_load_ok", ok, 1);
    do_run(7);
    rand_prog();
    do_start();
    do_load(6, 1'b1, ok);
    chk("bp_load_ok", ok, 1);
    do_run(-1);
    rand_prog();
    do_start();
    do_load(3, 1'b0, ok);
    do_run(MAXC - 1);
    rand_prog();
    do_start();
    do_load(DEPTH + 2, 1'b0, ok);
    chk("ovf_not_ok", ok, 0);
    do_start();
    do_load(4, 1'b0, ok);
    chk("reload_ok", ok, 1);
    do_run(2);
    rand_prog();
    do_start();
    load_valid = 1'b1;
    load_data = prog[0];
    step();
    step();
    async_reset();
    do_start();
    do_load(3, 1'b0, ok);
    core_pc = halt_pc + 32'h4;
    step();
    step();
    async_reset();
    for (int t = 0; t < 8; t++) begin
      int n, h;
      rand_prog();
      n = $urandom_range(1, DEPTH + 3);
      h = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, MAXC - 1));
      do_start();
      do_load(n, 1'($urandom_range(0, 1)), ok);
      chk("rnd_load_ok", ok, n <= DEPTH);
      if (ok) do_run(h);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
